rtc_bus_seq: RTL and testbench

- Parametrised successor to the fixed-count RTC read controller. It sequences a burst of NREG register accesses over the RTC's multiplexed address/data bus. Each access is an address cycle followed by a data cycle, read or write.
- Strobe widths and setup gaps are parameters, not hard-coded counts.
- Sits between the top-level RTC control FSM and the bidirectional pad logic. On reads, it delivers each captured byte to the VGA path with an index and a one-hot field flag.

---
 rtl/rtc_pkg.sv | 40 ++++
 rtl/rtc_phase_timer.sv | 28 ++
 rtl/rtc_bus_seq.sv | 183 ++++++++++++++++++
 tb/tb_rtc_bus_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC multiplexed-bus sequencer.
// Register addresses and field flags follow the VGA clock/timer display order.
package rtc_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_A_ACT,
      S_A_IDLE,
      S_D_ACT,
      S_D_IDLE,
      S_FIN
   } state_t;

   localparam int RTC_NREG_DEF = 9;

   localparam logic [7:0] RTC_ADDR_SEC   = 8'h21;
   localparam logic [7:0] RTC_ADDR_MIN   = 8'h22;
   localparam logic [7:0] RTC_ADDR_HOUR  = 8'h23;
   localparam logic [7:0] RTC_ADDR_DAY   = 8'h24;
   localparam logic [7:0] RTC_ADDR_MONTH = 8'h25;
   localparam logic [7:0] RTC_ADDR_YEAR  = 8'h26;
   localparam logic [7:0] RTC_ADDR_TMR_S = 8'h41;
   localparam logic [7:0] RTC_ADDR_TMR_M = 8'h42;
   localparam logic [7:0] RTC_ADDR_TMR_H = 8'h43;

   localparam logic [RTC_NREG_DEF-1:0] FLD_SEC   = 9'b0_0000_0001;
   localparam logic [RTC_NREG_DEF-1:0] FLD_MIN   = 9'b0_0000_0010;
   localparam logic [RTC_NREG_DEF-1:0] FLD_HOUR  = 9'b0_0000_0100;
   localparam logic [RTC_NREG_DEF-1:0] FLD_DAY   = 9'b0_0000_1000;
   localparam logic [RTC_NREG_DEF-1:0] FLD_MONTH = 9'b0_0001_0000;
   localparam logic [RTC_NREG_DEF-1:0] FLD_YEAR  = 9'b0_0010_0000;
   localparam logic [RTC_NREG_DEF-1:0] FLD_TMR_S = 9'b0_0100_0000;
   localparam logic [RTC_NREG_DEF-1:0] FLD_TMR_M = 9'b0_1000_0000;
   localparam logic [RTC_NREG_DEF-1:0] FLD_TMR_H = 9'b1_0000_0000;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter timing one bus phase; tc is high while the count is zero.
// Loading T-1 on phase entry makes the phase last exactly T cycles.
module rtc_phase_timer #(
   parameter int CW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          tc
);

   logic [CW-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign tc = (cnt == '0);

endmodule

// File: rtl/rtc_bus_seq.sv
// Burst sequencer for the RTC multiplexed address/data bus: NREG address+data
// accesses per burst, read or write, with registered pad and VGA-side outputs.
module rtc_bus_seq
   import rtc_pkg::*;
#(
   parameter int DW     = 8,
   parameter int NREG   = RTC_NREG_DEF,
   parameter int T_ACT  = 22,
   parameter int T_IDLE = 24,
   parameter int IW     = (NREG > 1) ? $clog2(NREG) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               mode_wr,
   input  logic               abort,
   input  logic [NREG*DW-1:0] addr_tbl,
   input  logic [NREG*DW-1:0] wdata_tbl,
   input  logic [DW-1:0]      bus_in,
   output logic [DW-1:0]      bus_out,
   output logic               bus_oe,
   output logic               cs_n,
   output logic               ad_n,
   output logic               rd_n,
   output logic               wr_n,
   output logic               busy,
   output logic               done,
   output logic [DW-1:0]      rdata,
   output logic [IW-1:0]      rdata_idx,
   output logic               rdata_valid,
   output logic [NREG-1:0]    rdata_onehot
);

   localparam int T_MAX = max_int(T_ACT, T_IDLE);
   localparam int CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   state_t        state, state_nxt;
   logic [IW-1:0] idx;
   logic          mode_q;
   logic          last_idx;
   logic          tc;
   logic          tmr_load;
   logic [CW-1:0] tmr_val;
   logic          cap_pending;

   logic          cs_n_d, ad_n_d, rd_n_d, wr_n_d, oe_d, busy_d, done_d, cap_d;
   logic [DW-1:0] bus_out_d;

   assign last_idx = (idx == IW'(NREG - 1));

   rtc_phase_timer #(.CW(CW)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tc       (tc)
   );

   always_ff @(posedge clk) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start)  state_nxt = S_A_ACT;
         S_A_ACT:  if (tc)     state_nxt = S_A_IDLE;
         S_A_IDLE: if (tc)     state_nxt = S_D_ACT;
         S_D_ACT:  if (tc)     state_nxt = S_D_IDLE;
         S_D_IDLE: if (tc)     state_nxt = last_idx ? S_FIN : S_A_ACT;
         S_FIN:                state_nxt = S_IDLE;
         default:              state_nxt = S_IDLE;
      endcase
      if (abort)
         state_nxt = S_IDLE;
   end

   // Every state change restarts the phase timer with the new phase length.
   assign tmr_load = (state_nxt != state);
   assign tmr_val  = (state_nxt == S_A_ACT || state_nxt == S_D_ACT) ? CW'(T_ACT - 1)
                                                                    : CW'(T_IDLE - 1);

   always_ff @(posedge clk) begin
      if (reset) begin
         idx    <= '0;
         mode_q <= 1'b0;
      end else if (state == S_IDLE && start && !abort) begin
         idx    <= '0;
         mode_q <= mode_wr;
      end else if (state == S_D_IDLE && tc && !last_idx) begin
         idx    <= idx + 1'b1;
      end
   end

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      cs_n_d    = 1'b1;
      ad_n_d    = 1'b1;
      rd_n_d    = 1'b1;
      wr_n_d    = 1'b1;
      oe_d      = 1'b0;
      bus_out_d = bus_out;
      busy_d    = busy;
      done_d    = 1'b0;
      cap_d     = 1'b0;
      case (state)
         S_IDLE: if (start) busy_d = 1'b1;
         S_A_ACT: begin
            cs_n_d    = 1'b0;
            ad_n_d    = 1'b0;
            oe_d      = 1'b1;
            bus_out_d = addr_tbl[int'(idx)*DW +: DW];
         end
         S_D_ACT: begin
            cs_n_d = 1'b0;
            if (mode_q) begin
               wr_n_d    = 1'b0;
               oe_d      = 1'b1;
               bus_out_d = wdata_tbl[int'(idx)*DW +: DW];
            end else begin
               rd_n_d = 1'b0;
               cap_d  = tc;
            end
         end
         S_FIN: begin
            done_d = 1'b1;
            busy_d = 1'b0;
         end
         default: ;
      endcase
      if (abort) begin
         cs_n_d = 1'b1;
         ad_n_d = 1'b1;
         rd_n_d = 1'b1;
         wr_n_d = 1'b1;
         oe_d   = 1'b0;
         busy_d = 1'b0;
         done_d = 1'b0;
         cap_d  = 1'b0;
      end
   end

   // Strobes lag the state by one cycle, so the read byte is taken at the edge
   // that ends the final rd_n-low cycle (cap_pending marks that edge).
   always_ff @(posedge clk) begin
      if (reset) begin
         cs_n         <= 1'b1;
         ad_n         <= 1'b1;
         rd_n         <= 1'b1;
         wr_n         <= 1'b1;
         bus_oe       <= 1'b0;
         bus_out      <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         cap_pending  <= 1'b0;
         rdata        <= '0;
         rdata_idx    <= '0;
         rdata_valid  <= 1'b0;
         rdata_onehot <= '0;
      end else begin
         cs_n         <= cs_n_d;
         ad_n         <= ad_n_d;
         rd_n         <= rd_n_d;
         wr_n         <= wr_n_d;
         bus_oe       <= oe_d;
         bus_out      <= bus_out_d;
         busy         <= busy_d;
         done         <= done_d;
         cap_pending  <= cap_d;
         rdata_valid  <= cap_pending && !abort;
         rdata_onehot <= '0;
         if (cap_pending && !abort) begin
            rdata        <= bus_in;
            rdata_idx    <= idx;
            rdata_onehot <= NREG'(1) << idx;
         end
      end
   end

endmodule

// File: tb/tb_rtc_bus_seq.sv
// Self-checking bench for rtc_bus_seq: directed and random bursts against a
// cycle-offset reference model derived from the phase lengths.
module tb_rtc_bus_seq;

   localparam int DW     = 8;
   localparam int NREG   = 3;
   localparam int T_ACT  = 4;
   localparam int T_IDLE = 2;
   localparam int IW     = 2;
   localparam int PER    = 2 * (T_ACT + T_IDLE);
   localparam int BURST  = NREG * PER;

   logic               clk = 1'b0;
   logic               reset, start, mode_wr, abort;
   logic [NREG*DW-1:0] addr_tbl, wdata_tbl;
   logic [DW-1:0]      bus_in, bus_out, rdata;
   logic               bus_oe, cs_n, ad_n, rd_n, wr_n, busy, done, rdata_valid;
   logic [IW-1:0]      rdata_idx;
   logic [NREG-1:0]    rdata_onehot;

   int checks = 0;
   int errors = 0;

   logic [7:0] addr_m  [NREG];
   logic [7:0] wdata_m [NREG];
   logic [7:0] rd_m    [NREG];
   logic [7:0] exp_rdata;
   int         exp_idx;

   always #5 clk = ~clk;

   rtc_bus_seq #(
      .DW(DW), .NREG(NREG), .T_ACT(T_ACT), .T_IDLE(T_IDLE), .IW(IW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .mode_wr      (mode_wr),
      .abort        (abort),
      .addr_tbl     (addr_tbl),
      .wdata_tbl    (wdata_tbl),
      .bus_in       (bus_in),
      .bus_out      (bus_out),
      .bus_oe       (bus_oe),
      .cs_n         (cs_n),
      .ad_n         (ad_n),
      .rd_n         (rd_n),
      .wr_n         (wr_n),
      .busy         (busy),
      .done         (done),
      .rdata        (rdata),
      .rdata_idx    (rdata_idx),
      .rdata_valid  (rdata_valid),
      .rdata_onehot (rdata_onehot)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load_tables();
      for (int i = 0; i < NREG; i++) begin
         addr_tbl[i*DW +: DW]  = addr_m[i];
         wdata_tbl[i*DW +: DW] = wdata_m[i];
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, ".cs_n"},   cs_n, 1);
      chk({tag, ".ad_n"},   ad_n, 1);
      chk({tag, ".rd_n"},   rd_n, 1);
      chk({tag, ".wr_n"},   wr_n, 1);
      chk({tag, ".oe"},     bus_oe, 0);
      chk({tag, ".busy"},   busy, 0);
      chk({tag, ".done"},   done, 0);
      chk({tag, ".valid"},  rdata_valid, 0);
      chk({tag, ".onehot"}, rdata_onehot, 0);
      chk({tag, ".rdata"},  rdata, exp_rdata);
      chk({tag, ".ridx"},   rdata_idx, exp_idx);
   endtask

   // Called at a falling edge. t counts rising edges from the one that samples start.
   task automatic run_burst(input bit wr, input int abort_t, input int reset_t, input int restart_t);
      int k, i, p, stop_from;
      bit a_ph, d_ph, exp_valid;
      stop_from = BURST + 100;
      start   = 1'b1;
      mode_wr = wr;
      for (int t = 0; t <= BURST + 2; t++) begin
         @(posedge clk);
         @(negedge clk);
         start   = 1'b0;
         mode_wr = ~wr;
         abort   = 1'b0;
         reset   = 1'b0;
         a_ph    = 1'b0;
         d_ph    = 1'b0;
         i       = 0;
         if (t >= stop_from) begin
            chk_quiet("stopped");
         end else if (t == 0) begin
            chk("t0.busy", busy, 1);
            chk("t0.cs_n", cs_n, 1);
            chk("t0.done", done, 0);
         end else if (t <= BURST) begin
            k = t - 1;
            i = k / PER;
            p = k % PER;
            a_ph = (p < T_ACT);
            d_ph = (p >= T_ACT + T_IDLE) && (p < 2*T_ACT + T_IDLE);
            exp_valid = !wr && (p == 2*T_ACT + T_IDLE);
            if (exp_valid) begin
               exp_rdata = rd_m[i];
               exp_idx   = i;
            end
            chk("cs_n", cs_n, !(a_ph || d_ph));
            chk("ad_n", ad_n, !a_ph);
            chk("rd_n", rd_n, !(d_ph && !wr));
            chk("wr_n", wr_n, !(d_ph && wr));
            chk("bus_oe", bus_oe, a_ph || (d_ph && wr));
            if (a_ph)        chk("bus_out.addr", bus_out, addr_m[i]);
            if (d_ph && wr)  chk("bus_out.wdata", bus_out, wdata_m[i]);
            chk("rdata_valid", rdata_valid, exp_valid);
            chk("rdata_onehot", rdata_onehot, exp_valid ? (32'd1 << i) : 32'd0);
            chk("rdata", rdata, exp_rdata);
            chk("rdata_idx", rdata_idx, exp_idx);
            chk("busy", busy, 1);
            chk("done", done, 0);
         end else if (t == BURST + 1) begin
            chk("fin.done", done, 1);
            chk("fin.busy", busy, 0);
            chk("fin.cs_n", cs_n, 1);
         end else begin
            chk("post.done", done, 0);
            chk("post.busy", busy, 0);
         end
         bus_in = (t >= 1 && t <= BURST && d_ph) ? rd_m[i] : DW'($urandom);
         if (t == restart_t) begin
            start   = 1'b1;
            mode_wr = ~wr;
         end
         if (t == abort_t) begin
            abort     = 1'b1;
            stop_from = t + 1;
         end
         if (t == reset_t) begin
            reset     = 1'b1;
            stop_from = t + 1;
            exp_rdata = '0;
            exp_idx   = 0;
         end
      end
   endtask

   // Bus protocol invariants, checked on every cycle outside reset.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         chk("proto.rd_wr_overlap", !(rd_n === 1'b0 && wr_n === 1'b0), 1);
         chk("proto.ad_needs_oe", (ad_n === 1'b1) || (bus_oe === 1'b1), 1);
         if (busy === 1'b0) chk("proto.cs_idle", cs_n, 1);
      end
   end

   initial begin
      reset = 1'b1; start = 1'b0; mode_wr = 1'b0; abort = 1'b0; bus_in = '0;
      addr_m  = '{8'h21, 8'h22, 8'h23};
      wdata_m = '{8'h58, 8'h59, 8'h07};
      rd_m    = '{8'h45, 8'h30, 8'h12};
      load_tables();
      exp_rdata = '0;
      exp_idx   = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.bus_out", bus_out, 0);
      chk("rst.rdata", rdata, 0);
      chk("rst.ridx", rdata_idx, 0);
      chk_quiet("rst");
      reset = 1'b0;
      @(negedge clk);

      run_burst(1'b0, -1, -1, -1);   // directed read
      run_burst(1'b1, -1, -1, -1);   // directed write
      run_burst(1'b0, 19, -1, -1);   // abort in second D_ACT
      run_burst(1'b0, -1, -1, 5);    // start while busy

      // abort and start together in IDLE
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      for (int n = 0; n < 3; n++) begin
         chk_quiet("abort_start_idle");
         @(negedge clk);
      end

      run_burst(1'b0, -1, 13, -1);   // reset in A_ACT of index 1
      run_burst(1'b0, -1, -1, -1);   // fresh burst after reset

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < NREG; i++) begin
            addr_m[i]  = 8'($urandom);
            wdata_m[i] = 8'($urandom);
            rd_m[i]    = 8'($urandom);
         end
         load_tables();
         run_burst(1'($urandom_range(0, 1)), -1, -1, int'($urandom_range(1, BURST - 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
